// File: rtl/ser_arith_pkg.sv
// ----------------------------------------------------------------------------
// ser_arith_pkg
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t        : control FSM encoding (IDLE, SHIFT, DONE), 2 bits
//   DEFAULT_WIDTH  : default operand/result width
// Optional feature macro used by the blocks importing this package:
//   SERIAL_SUB_ADD_MODE_EN (adds a sub/add mode select)
// ----------------------------------------------------------------------------
package ser_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_if
// Request/response bundle of the serial subtractor.
//   start        : request, sampled only when the block is IDLE or DONE
//   a, b, bin    : operands, latched together with an accepted start
//   sub          : mode select (only with SERIAL_SUB_ADD_MODE_EN), 1 = subtract
//   busy         : high while the operation is shifting
//   done         : one-cycle pulse, d/bout valid from this cycle on
//   d, bout      : registered result and borrow (carry in add mode)
//   state        : debug view of the control FSM
// Modports: master (requester side), slave (serial_subtractor side).
//
// Handshake: a start seen at a clock edge while busy=0 is accepted at that
// edge and the operands are captured there; while busy=1 start is ignored
// and the operand inputs may change freely. The result is presented with a
// single done pulse; d/bout then hold until the next result or reset.
// A start asserted during the done cycle is accepted (back-to-back).
// ----------------------------------------------------------------------------
interface serial_subtractor_if
    import ser_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    state_t           state;

    modport master (
        output start,
        output a,
        output b,
        output bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
        output sub,
`endif
        input  busy,
        input  done,
        input  d,
        input  bout,
        input  state
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
        input  sub,
`endif
        output busy,
        output done,
        output d,
        output bout,
        output state
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
// Combinational 1-bit subtract cell: d = a - b - bin, bout = borrow out.
// Ports:
//   a, b, bin : input bits
//   sub       : mode (only with SERIAL_SUB_ADD_MODE_EN); 1 = subtract,
//               0 = add (bin acts as carry-in, bout as carry-out)
//   d         : difference (or sum) bit
//   bout      : borrow-out (or carry-out)
// ----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic sub,
`endif
    output logic d,
    output logic bout
);

    logic x;

    assign x = a ^ b;
    // The result bit is the same XOR for addition and subtraction.
    assign d = x ^ bin;

`ifdef SERIAL_SUB_ADD_MODE_EN
    assign bout = sub ? ((~a & b) | (~x & bin))
                      : ((a & b) | (x & bin));
`else
    // Borrow when b exceeds a, or when they are equal and a borrow comes in.
    assign bout = (~a & b) | (~x & bin);
`endif

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor: d = a - b - bin (mod 2^WIDTH), LSB first, one bit
// per clock through a single full_subtractor cell and one borrow flip-flop.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : serial_subtractor_if.slave (start/a/b/bin[/sub] in,
//          busy/done/d/bout/state out)
// Parameters:
//   WIDTH : operand/result width, >= 2
// Optional feature: SERIAL_SUB_ADD_MODE_EN adds bus.sub; sub=0 selects
// serial addition with bout as carry-out.
// Timing: start accepted at edge 0, WIDTH SHIFT cycles (busy=1), done high
// in the cycle after edge WIDTH.
// ----------------------------------------------------------------------------
module serial_subtractor
    import ser_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    count;
    logic             borrow;
    logic             bout_q;

    logic             bit_d;
    logic             bit_bout;
    logic             load;
    logic             shift;
    logic             last;

`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             sub_q;
`endif

    // ------------------------------------------------------------------
    // Bit slice
    // ------------------------------------------------------------------
    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .sub  (sub_q),
`endif
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign last = (count == LAST_BIT);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A new request in the done cycle starts the next op directly.
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            d_q    <= '0;
            count  <= '0;
            borrow <= 1'b0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            sub_q  <= 1'b1;
`endif
        end else if (load) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            r_sr   <= '0;
            count  <= '0;
            borrow <= bus.bin;
`ifdef SERIAL_SUB_ADD_MODE_EN
            sub_q  <= bus.sub;
`endif
        end else if (shift) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            borrow <= bit_bout;
            // Result bits enter at the MSB so the first (LSB) bit ends up
            // at position 0 after WIDTH shifts.
            r_sr   <= {bit_d, r_sr[WIDTH-1:1]};
            if (last) begin
                // Take the final bit straight from the cell; r_sr would only
                // hold it one edge later.
                d_q    <= {bit_d, r_sr[WIDTH-1:1]};
                bout_q <= bit_bout;
            end else begin
                count  <= count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy  = (state == SHIFT);
    assign bus.done  = (state == DONE);
    assign bus.d     = d_q;
    assign bus.bout  = bout_q;
    assign bus.state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=4). Requests push the
// expected {bout, d} into exp_q; a monitor pops and compares on every done
// pulse. Directed vectors use hand-computed values; a randomized phase uses
// a word-level reference model.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;
    import ser_arith_pkg::*;

    localparam int W = 4;

    logic clk;
    logic rst;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W:0] exp_q[$];
    int         n_cmp;
    int         n_err;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: {bout, d} for one operation
    // ------------------------------------------------------------------
    function automatic logic [W:0] ref_op(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic         c,
                                          input logic         s);
        if (s) begin
            return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        end
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // ------------------------------------------------------------------
    // Checks and driver tasks
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Called at a negedge: presents one request, returns 1 time unit after
    // the accepting edge with the operand inputs scrambled.
    task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                               input logic tbin, input logic tsub,
                               input bit push, input logic [W:0] exp);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.bin   = tbin;
`ifdef SERIAL_SUB_ADD_MODE_EN
        bus.sub   = tsub;
`endif
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom_range(0, (1 << W) - 1));
        bus.b     = W'($urandom_range(0, (1 << W) - 1));
        bus.bin   = 1'($urandom_range(0, 1));
`ifdef SERIAL_SUB_ADD_MODE_EN
        bus.sub   = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tbin, input logic tsub,
                         input bit push, input logic [W:0] exp);
        @(negedge clk);
        drive_start(ta, tb_, tbin, tsub, push, exp);
    endtask

    // Returns at the negedge where done is high, or flags a timeout.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 2 * W + 4);
        if (!bus.done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: done not seen within %0d cycles", name, n);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL result: unexpected done, got bout=%0d d=%0d",
                         bus.bout, bus.d);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({bus.bout, bus.d} !== e) begin
                    n_err++;
                    $display("FAIL result: got bout=%0d d=%0d, want bout=%0d d=%0d",
                             bus.bout, bus.d, e[W], e[W-1:0]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int pulses;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
        bus.sub   = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy",  32'(bus.busy),  0);
        check("reset_done",  32'(bus.done),  0);
        check("reset_d",     32'(bus.d),     0);
        check("reset_bout",  32'(bus.bout),  0);
        check("reset_state", 32'(bus.state), 32'(IDLE));
        rst = 1'b0;

        // 12 - 8 - 1 = 3, no borrow; busy for exactly 4 cycles
        issue(4'd12, 4'd8, 1'b1, 1'b1, 1'b1, {1'b0, 4'd3});
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("t1_busy", 32'(bus.busy), 1);
            check("t1_no_done", 32'(bus.done), 0);
        end
        @(negedge clk);
        check("t1_done_cycle", 32'(bus.done), 1);
        check("t1_busy_off", 32'(bus.busy), 0);
        @(negedge clk);
        check("t1_done_single", 32'(bus.done), 0);
        check("t1_hold_d", 32'(bus.d), 3);
        check("t1_hold_bout", 32'(bus.bout), 0);

        // 15 - 6 = 9, then back-to-back 4 - 10 = 10 with borrow
        issue(4'd15, 4'd6, 1'b0, 1'b1, 1'b1, {1'b0, 4'd9});
        wait_done("t2a_done");
        drive_start(4'd4, 4'd10, 1'b0, 1'b1, 1'b1, {1'b1, 4'd10});
        @(negedge clk);
        check("t2_b2b_busy", 32'(bus.busy), 1);
        wait_done("t2b_done");

        // 0 - 0 - 1 = 15 with borrow; start held mid-SHIFT is ignored
        issue(4'd0, 4'd0, 1'b1, 1'b1, 1'b1, {1'b1, 4'd15});
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd5;
        bus.b     = 4'd5;
        bus.bin   = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("t3_one_done", 32'(pulses), 1);

        // Reset mid-SHIFT aborts: no result expected
        issue(4'd9, 4'd2, 1'b0, 1'b1, 1'b0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t4_rst_busy",  32'(bus.busy),  0);
        check("t4_rst_done",  32'(bus.done),  0);
        check("t4_rst_d",     32'(bus.d),     0);
        check("t4_rst_bout",  32'(bus.bout),  0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("t4_no_done", 32'(pulses), 0);
        issue(4'd7, 4'd7, 1'b0, 1'b1, 1'b1, {1'b0, 4'd0});
        @(negedge clk);
        check("t4_accept_busy", 32'(bus.busy), 1);
        wait_done("t4_done");

`ifdef SERIAL_SUB_ADD_MODE_EN
        // Add mode: 3 + 8 + 1 = 12; 10 + 10 = 20 -> 4 with carry
        issue(4'd3, 4'd8, 1'b1, 1'b0, 1'b1, {1'b0, 4'd12});
        wait_done("add1_done");
        issue(4'd10, 4'd10, 1'b0, 1'b0, 1'b1, {1'b1, 4'd4});
        wait_done("add2_done");
`endif

        // Randomized operations, some issued back-to-back in the done cycle
        for (int k = 0; k < 1000; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic         rs;
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rc = 1'($urandom_range(0, 1));
            rs = 1'b1;
`ifdef SERIAL_SUB_ADD_MODE_EN
            rs = 1'($urandom_range(0, 1));
`endif
            if (k > 0 && bus.done && $urandom_range(0, 1) == 1) begin
                drive_start(ra, rb, rc, rs, 1'b1, ref_op(ra, rb, rc, rs));
            end else begin
                issue(ra, rb, rc, rs, 1'b1, ref_op(ra, rb, rc, rs));
            end
            wait_done("rand_done");
        end

        repeat (W + 4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
